// File: rtl/mspu_avmm_pkg.sv
// rtl/mspu_avmm_pkg.sv - shared types and constants for the AVMM memory responder
// Contents: FSM state enum, word/byte-offset geometry, burst-length helper.
package mspu_avmm_pkg;

    localparam int BYTE_OFF_W = 6;              // byte offset bits within one word
    localparam int WORD_W     = 512;            // data word width in bits
    localparam int BE_W       = WORD_W / 8;     // byte enables per word
    localparam int BURST_W    = 3;              // s_burstcount width

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } state_e;

    // A burstcount of zero is treated as a single-beat burst.
    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/avmm_be_ram.sv
// rtl/avmm_be_ram.sv - single-port 512-bit RAM with per-byte write enables
// Ports: clk, reset (clears only the read register), wr_en/rd_en, addr,
//        wdata/be (write word and byte enables), rdata (registered, 1-cycle read,
//        holds its value between reads).
module avmm_be_ram
    import mspu_avmm_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Contents survive reset; only enabled bytes are overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/avmm_mem_responder.sv
// rtl/avmm_mem_responder.sv - Avalon-MM burst slave backed by a byte-enabled RAM
// Ports: clk, reset (sync, active-high); s_address/s_burstcount/s_read/s_write/
//        s_writedata/s_byteenable command inputs; s_waitrequest, s_readdata,
//        s_readdatavalid responses; stall_inject forces waitrequest;
//        rd_beats/wr_beats beat counters; err_sticky protocol-error flag.
module avmm_mem_responder
    import mspu_avmm_pkg::*;
#(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int RD_LATENCY      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        s_address,
    input  logic [BURST_W-1:0] s_burstcount,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [WORD_W-1:0]  s_writedata,
    input  logic [BE_W-1:0]    s_byteenable,
    output logic               s_waitrequest,
    output logic [WORD_W-1:0]  s_readdata,
    output logic               s_readdatavalid,
    input  logic               stall_inject,
    output logic [31:0]        rd_beats,
    output logic [31:0]        wr_beats,
    output logic               err_sticky
);

    localparam int AW = ADDR_WORDS_LOG2;

    state_e               state_d, state_q;
    logic [BURST_W-1:0]   remaining_d, remaining_q;
    logic [AW-1:0]        next_word_d, next_word_q;
    logic [31:0]          rd_beats_d, rd_beats_q;
    logic [31:0]          wr_beats_d, wr_beats_q;
    logic                 err_d, err_q;
    logic [RD_LATENCY-1:0] vld_d, vld_q;

    logic [AW-1:0]        cmd_word;
    logic [BURST_W-1:0]   cmd_len;
    logic                 accept;
    logic                 ram_wr_en;
    logic                 ram_rd_en;
    logic [AW-1:0]        ram_addr;
    logic [WORD_W-1:0]    ram_rdata;

    // Address bits outside the word index wrap the memory and are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_address[63:AW+BYTE_OFF_W], s_address[BYTE_OFF_W-1:0]};

    assign cmd_word      = s_address[AW+BYTE_OFF_W-1:BYTE_OFF_W];
    assign cmd_len       = burst_len(s_burstcount);
    assign s_waitrequest = reset | stall_inject | (state_q == RBURST);
    assign accept        = (s_read | s_write) & ~s_waitrequest;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        next_word_d = next_word_q;
        err_d       = err_q;
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_addr    = next_word_q;

        case (state_q)
            IDLE: begin
                ram_addr = cmd_word;
                // Write wins a simultaneous read/write request.
                if (accept && s_write) begin
                    ram_wr_en = 1'b1;
                    if (s_read) begin
                        err_d = 1'b1;
                    end
                    if (cmd_len > BURST_W'(1)) begin
                        state_d     = WBURST;
                        remaining_d = cmd_len - BURST_W'(1);
                        next_word_d = cmd_word + 1'b1;
                    end
                end else if (accept && s_read) begin
                    ram_rd_en = 1'b1;
                    if (cmd_len > BURST_W'(1)) begin
                        state_d     = RBURST;
                        remaining_d = cmd_len - BURST_W'(1);
                        next_word_d = cmd_word + 1'b1;
                    end
                end
            end
            WBURST: begin
                if (s_read) begin
                    err_d = 1'b1;
                end
                if (s_write && !s_waitrequest) begin
                    ram_wr_en   = 1'b1;
                    next_word_d = next_word_q + 1'b1;
                    remaining_d = remaining_q - BURST_W'(1);
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RBURST: begin
                // One beat per cycle; stall_inject only gates new commands.
                if (!reset) begin
                    ram_rd_en   = 1'b1;
                    next_word_d = next_word_q + 1'b1;
                    remaining_d = remaining_q - BURST_W'(1);
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_beats_d = rd_beats_q + 32'(ram_rd_en);
        wr_beats_d = wr_beats_q + 32'(ram_wr_en);

        // vld_q[0] lines up with the RAM output register.
        vld_d[0] = ram_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            next_word_q <= '0;
            rd_beats_q  <= '0;
            wr_beats_q  <= '0;
            err_q       <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            next_word_q <= next_word_d;
            rd_beats_q  <= rd_beats_d;
            wr_beats_q  <= wr_beats_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
        end
    end

    avmm_be_ram #(
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .wr_en (ram_wr_en),
        .rd_en (ram_rd_en),
        .addr  (ram_addr),
        .wdata (s_writedata),
        .be    (s_byteenable),
        .rdata (ram_rdata)
    );

    // Data stages load only on a valid beat so the output holds the last beat.
    if (RD_LATENCY == 1) begin : g_no_pipe
        assign s_readdata = ram_rdata;
    end else begin : g_pipe
        logic [WORD_W-1:0] dat_d [RD_LATENCY-1];
        logic [WORD_W-1:0] dat_q [RD_LATENCY-1];

        always_comb begin
            dat_d[0] = vld_q[0] ? ram_rdata : dat_q[0];
            for (int i = 1; i < RD_LATENCY - 1; i++) begin
                dat_d[i] = vld_q[i] ? dat_q[i-1] : dat_q[i];
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < RD_LATENCY - 1; i++) begin
                if (reset) begin
                    dat_q[i] <= '0;
                end else begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end

        assign s_readdata = dat_q[RD_LATENCY-2];
    end

    assign s_readdatavalid = vld_q[RD_LATENCY-1];
    assign rd_beats        = rd_beats_q;
    assign wr_beats        = wr_beats_q;
    assign err_sticky      = err_q;

endmodule

// File: doc/avmm_mem_responder.md
AVMM_MEM_RESPONDER -- requirements
Module: avmm_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WORDS_LOG2, default 10, memory depth in 512-bit words.
REQ-002 SHALL have parameter RD_LATENCY, default 3, range 1..8; cycles from beat issue to readdatavalid.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s_address  input  64 (byte address); s_burstcount  input  3; s_read  input  1; s_write  input  1.
REQ-006 SHALL have ports s_writedata  input  512; s_byteenable  input  64.
REQ-007 SHALL have ports s_waitrequest  output  1; s_readdata  output  512; s_readdatavalid  output  1.
REQ-008 SHALL have port stall_inject  input  1; forces s_waitrequest high while asserted.
REQ-009 SHALL have ports rd_beats  output  32, wr_beats  output  32, err_sticky  output  1.

Function
REQ-010 SHALL act as an Avalon-MM slave responding to a 512-bit burst master; word index = s_address[ADDR_WORDS_LOG2+5:6]; higher bits and bits [5:0] ignored (modulo wrap).
REQ-011 SHALL treat s_burstcount 0 as 1; legal lengths are 1..7.
REQ-012 SHALL accept a command in any cycle where (s_read|s_write) && !s_waitrequest.
REQ-013 SHALL implement FSM IDLE, WBURST, RBURST; reset state IDLE.
REQ-014 IDLE: accepted write of length 1 -> stay IDLE; length >1 -> WBURST with remaining=len-1, next word=index+1.
REQ-015 WBURST: each beat with s_write && !s_waitrequest writes next word and increments it (wrap modulo depth); s_address ignored; remaining==1 on accepted beat -> IDLE.
REQ-016 SHALL apply s_byteenable per byte on every write beat; disabled bytes keep old contents.
REQ-017 IDLE: accepted read issues beat 0 in the accept cycle; length >1 -> RBURST, issuing one further beat per cycle, consecutive words, wrapping.
REQ-018 s_waitrequest SHALL be high in RBURST and whenever stall_inject=1, otherwise low; in WBURST it SHALL be low unless stall_inject=1.
REQ-019 Beat issued in cycle t SHALL produce s_readdatavalid=1 with its data in cycle t+RD_LATENCY; no gaps within a burst; readdatavalid has no backpressure.
REQ-020 A write accepted in cycle t SHALL be visible to any read beat issued in cycle t+1 or later.
REQ-021 s_read && s_write together in IDLE SHALL accept only the write and set err_sticky; s_read in WBURST SHALL be ignored and set err_sticky.
REQ-022 rd_beats/wr_beats SHALL increment by 1 per issued read beat/accepted write beat, wrapping at 2^32.
REQ-023 s_readdata SHALL hold the last valid beat's data when s_readdatavalid=0.

Reset
REQ-024 On reset: FSM IDLE, s_readdatavalid=0, latency pipeline flushed (in-flight beats discarded), s_readdata=0, rd_beats=0, wr_beats=0, err_sticky=0.
REQ-025 s_waitrequest SHALL be 1 during reset cycles and reflect REQ-018 from the first cycle after reset deasserts.
REQ-026 Memory contents SHALL NOT be cleared by reset; reset mid-burst abandons the burst without writing further words.

Structure
REQ-027 FSM state enum and word/byte-offset constants (6-bit byte offset, 512-bit word) SHALL live in shared package mspu_avmm_pkg.
REQ-028 Storage SHALL be one sub-module avmm_be_ram (single-port 512-bit RAM, 64 byte enables, 1-cycle read); remaining RD_LATENCY-1 stages are a valid/data shift register in the top.

Verification
REQ-029 Write addr 0x40, burst 1, data all 0xA5, be all-ones; read addr 0x40 burst 1 -> readdatavalid exactly RD_LATENCY cycles after accept, data all 0xA5, wr_beats=1, rd_beats=1.
REQ-030 Write burst 4 at 0x0 data 1,2,3,4; read burst 4 at 0x0 -> 4 consecutive valid beats 1,2,3,4; waitrequest high 3 cycles after read accept.
REQ-031 Write addr ((2^ADDR_WORDS_LOG2)-1)*64 burst 2 data 7,8 -> read addr 0x0 returns 8 (wrap).
REQ-032 Write all 0xFF to 0x80, then write 0x00 with byteenable 0x0000_0000_0000_000F -> read returns low 4 bytes 0x00, remaining 60 bytes 0xFF.
REQ-033 Assert s_read and s_write together in IDLE -> write performed, no readdatavalid, err_sticky=1 until reset.
REQ-034 Issue read burst 4, assert reset after 2nd valid beat -> no further readdatavalid, counters 0, subsequent read of same address returns pre-reset memory contents.
